// File: rtl/rll_key_query_ctrl_if.sv
// Harness-side handshake bundle for rll_key_query_ctrl.
// Ports: key bit stream, query request, response, key_loaded and query_cnt status.
interface rll_key_query_ctrl_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
);
   logic             key_bit_valid;
   logic             key_bit;
   logic             key_bit_ready;
   logic             key_loaded;
   logic             req_valid;
   logic [IN_W-1:0]  req_vec;
   logic             req_ready;
   logic             resp_valid;
   logic [OUT_W-1:0] resp_data;
   logic             resp_ready;
   logic [CNT_W-1:0] query_cnt;

   modport master (
      output key_bit_valid, key_bit, req_valid, req_vec, resp_ready,
      input  key_bit_ready, key_loaded, req_ready, resp_valid,
      input  resp_data, query_cnt
   );

   modport slave (
      input  key_bit_valid, key_bit, req_valid, req_vec, resp_ready,
      output key_bit_ready, key_loaded, req_ready, resp_valid,
      output resp_data, query_cnt
   );
endinterface

// File: rtl/rll_key_query_ctrl.sv
// Serial key loader and single-query sequencer for a key-locked netlist.
// Ports: clk, rst_n, bus (slave handshake), ckt_in/ckt_key drive, ckt_out sample.
module rll_key_query_ctrl #(
   parameter int IN_W       = 32,
   parameter int OUT_W      = 32,
   parameter int KEY_W      = 16,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   rll_key_query_ctrl_if.slave bus,
   output logic [IN_W-1:0]  ckt_in,
   output logic [KEY_W-1:0] ckt_key,
   input  logic [OUT_W-1:0] ckt_out
);
   localparam int IDX_W = $clog2(KEY_W);
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      ARMED,
      SETTLE,
      HOLD
   } state_t;

   state_t           state_q;
   logic [KEY_W-2:0] shift_q;
   logic [IDX_W-1:0] idx_q;
   logic [SET_W-1:0] settle_q;
   logic [OUT_W-1:0] resp_data_q;
   logic             resp_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic             key_acc;
   logic             req_acc;

   // A pending query blocks key bits in ARMED so it wins a tie.
   assign bus.key_bit_ready = (state_q == IDLE) ||
                              (state_q == SHIFT) ||
                              ((state_q == ARMED) && !bus.req_valid);
   assign bus.req_ready  = (state_q == ARMED);
   assign bus.key_loaded = (state_q == ARMED) ||
                           (state_q == SETTLE) ||
                           (state_q == HOLD);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.query_cnt  = cnt_q;

   assign key_acc = bus.key_bit_valid && bus.key_bit_ready;
   assign req_acc = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         settle_q     <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         cnt_q        <= '0;
         ckt_in       <= '0;
         ckt_key      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (key_acc) begin
                  shift_q[0] <= bus.key_bit;
                  idx_q      <= IDX_W'(1);
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               if (key_acc) begin
                  if (idx_q == IDX_W'(KEY_W - 1)) begin
                     // Whole key lands in one edge; netlist never sees a partial key.
                     ckt_key <= {bus.key_bit, shift_q};
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     state_q <= ARMED;
                  end else begin
                     shift_q[idx_q] <= bus.key_bit;
                     idx_q          <= idx_q + IDX_W'(1);
                  end
               end
            end
            ARMED: begin
               if (req_acc) begin
                  ckt_in   <= bus.req_vec;
                  settle_q <= SET_W'(SETTLE_CYC - 1);
                  state_q  <= SETTLE;
               end else if (key_acc) begin
                  shift_q[0] <= bus.key_bit;
                  idx_q      <= IDX_W'(1);
                  state_q    <= SHIFT;
               end
            end
            SETTLE: begin
               if (settle_q == '0) begin
                  resp_data_q  <= ckt_out;
                  resp_valid_q <= 1'b1;
                  state_q      <= HOLD;
               end else begin
                  settle_q <= settle_q - SET_W'(1);
               end
            end
            HOLD: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
                  state_q <= ARMED;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rll_key_query_ctrl.sv
// Directed bench for rll_key_query_ctrl with a toy locked netlist.
// Netlist: out = {in[31:16] + key, in[15:0] ^ key}; CNT_W=4 for saturation.
module tb_rll_key_query_ctrl;
   localparam int IN_W  = 32;
   localparam int OUT_W = 32;
   localparam int KEY_W = 16;
   localparam int SC    = 2;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [IN_W-1:0]  ckt_in;
   logic [KEY_W-1:0] ckt_key;
   logic [OUT_W-1:0] ckt_out;

   int checks;
   int failures;

   rll_key_query_ctrl_if #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .CNT_W(CNT_W)
   ) bus ();

   rll_key_query_ctrl #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .KEY_W     (KEY_W),
      .SETTLE_CYC(SC),
      .CNT_W     (CNT_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .ckt_in (ckt_in),
      .ckt_key(ckt_key),
      .ckt_out(ckt_out)
   );

   function automatic logic [31:0] nl(input logic [31:0] i,
                                      input logic [15:0] k);
      return {i[31:16] + k, i[15:0] ^ k};
   endfunction

   assign ckt_out = nl(ckt_in, ckt_key);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bits(input logic [15:0] k, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         int w;
         bus.key_bit_valid = 1'b1;
         bus.key_bit       = k[i];
         w = 0;
         while (!bus.key_bit_ready && w < 10) begin
            tick();
            w++;
         end
         if (w >= 10) chk("key_rdy_to", 32'(bus.key_bit_ready), 32'd1);
         tick();
      end
      bus.key_bit_valid = 1'b0;
   endtask

   task automatic do_query(input logic [31:0] v, input logic [31:0] exp,
                           input string tag);
      int n;
      chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_vec   = v;
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.resp_valid && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(SC));
      chk({tag, "_dat"}, bus.resp_data, exp);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.key_bit_valid = 1'b0;
      bus.key_bit       = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_vec       = '0;
      bus.resp_ready    = 1'b0;
      #1;
      chk("rst_key", 32'(ckt_key), 32'h0);
      chk("rst_in", ckt_in, 32'h0);
      chk("rst_loaded", 32'(bus.key_loaded), 32'd0);
      chk("rst_kbr", 32'(bus.key_bit_ready), 32'd1);
      chk("rst_rqr", 32'(bus.req_ready), 32'd0);
      chk("rst_rv", 32'(bus.resp_valid), 32'd0);
      chk("rst_cnt", 32'(bus.query_cnt), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: key load, commit only on the 16th accept edge
      load_bits(16'hA5C3, 0, 14);
      chk("t1_key_pre", 32'(ckt_key), 32'h0);
      chk("t1_ld_pre", 32'(bus.key_loaded), 32'd0);
      chk("t1_rqr_pre", 32'(bus.req_ready), 32'd0);
      load_bits(16'hA5C3, 15, 15);
      chk("t1_key", 32'(ckt_key), 32'hA5C3);
      chk("t1_ld", 32'(bus.key_loaded), 32'd1);
      chk("t1_cnt", 32'(bus.query_cnt), 32'd0);

      // 2: query, latency exactly SETTLE_CYC
      bus.req_valid = 1'b1;
      bus.req_vec   = 32'h0000_00FF;
      tick();
      bus.req_valid = 1'b0;
      chk("t2_in", ckt_in, 32'h0000_00FF);
      chk("t2_rv_e0", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("t2_rv_e1", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("t2_rv_e2", 32'(bus.resp_valid), 32'd1);
      chk("t2_dat", bus.resp_data, 32'hA5C3_A53C);

      // 3: backpressure then consume
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_rv", 32'(bus.resp_valid), 32'd1);
         chk("t3_dat", bus.resp_data, 32'hA5C3_A53C);
         chk("t3_rqr", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      chk("t3_rv_lo", 32'(bus.resp_valid), 32'd0);
      chk("t3_cnt", 32'(bus.query_cnt), 32'd1);
      chk("t3_rqr", 32'(bus.req_ready), 32'd1);

      // 4: query beats a simultaneous key bit
      bus.req_valid     = 1'b1;
      bus.req_vec       = 32'h0001_0000;
      bus.key_bit_valid = 1'b1;
      bus.key_bit       = 1'b1;
      #1;
      chk("t4_kbr", 32'(bus.key_bit_ready), 32'd0);
      tick();
      bus.req_valid     = 1'b0;
      bus.key_bit_valid = 1'b0;
      chk("t4_key", 32'(ckt_key), 32'hA5C3);
      chk("t4_ld", 32'(bus.key_loaded), 32'd1);
      chk("t4_kbr2", 32'(bus.key_bit_ready), 32'd0);
      tick();
      tick();
      chk("t4_dat", bus.resp_data, 32'hA5C4_A5C3);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      chk("t4_cnt", 32'(bus.query_cnt), 32'd2);

      // 5: reload interrupted by reset, then full reload
      load_bits(16'h1234, 0, 7);
      chk("t5_ld", 32'(bus.key_loaded), 32'd0);
      chk("t5_oldkey", 32'(ckt_key), 32'hA5C3);
      rst_n = 1'b0;
      #1;
      chk("t5_key", 32'(ckt_key), 32'h0);
      chk("t5_in", ckt_in, 32'h0);
      chk("t5_kbr", 32'(bus.key_bit_ready), 32'd1);
      chk("t5_rqr", 32'(bus.req_ready), 32'd0);
      chk("t5_cnt", 32'(bus.query_cnt), 32'd0);
      chk("t5_rd", bus.resp_data, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      load_bits(16'h1234, 0, 15);
      chk("t5_key2", 32'(ckt_key), 32'h1234);
      chk("t5_ld2", 32'(bus.key_loaded), 32'd1);

      // 6: counter saturation, cleared by a new commit
      for (int q = 0; q < 20; q++) begin
         logic [31:0] v;
         v = 32'(q) * 32'h0003_0101;
         do_query(v, nl(v, 16'h1234), "t6_q");
         chk("t6_cnt", 32'(bus.query_cnt), (q + 1 > 15) ? 32'd15 : 32'(q + 1));
      end
      load_bits(16'hA5C3, 0, 15);
      chk("t6_cnt0", 32'(bus.query_cnt), 32'd0);
      do_query(32'h0000_00FF, 32'hA5C3_A53C, "t6_fin");
      chk("t6_cnt1", 32'(bus.query_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
